// File: rtl/regfile_pkg.sv
// Shared definitions for the ID-stage register file and its scoreboard.
package regfile_pkg;

    // Default geometry of the MIPS integer register file.
    localparam int ADDR_DEF = 5;
    localparam int SIZE_DEF = 32;

    typedef logic [7:0] byte_t;

    // Busy vector for the default geometry, one bit per architectural register.
    typedef logic [(1 << ADDR_DEF)-1:0] busy_vec_t;

    // Byte-enable merge: an enabled byte takes the new value, otherwise keeps the old one.
    function automatic byte_t be_merge_byte(input byte_t old_b, input byte_t new_b, input logic en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between the ID/WB pipeline logic (master) and the register file (slave).
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int ADDR = ADDR_DEF,
    parameter int SIZE = SIZE_DEF,
    parameter int NRD  = 2
);

    // Write-back port
    logic                  Write_Reg;
    logic [ADDR-1:0]       W_Addr;
    logic [SIZE-1:0]       W_Data;
    logic [SIZE/8-1:0]     W_Be;
    logic                  W_Release;

    // Operand read ports
    logic [NRD*ADDR-1:0]   R_Addr;
    logic [NRD*SIZE-1:0]   R_Data;
    logic [NRD-1:0]        R_Busy;

    // Scoreboard control from issue
    logic                  Sb_Set;
    logic [ADDR-1:0]       Sb_Addr;
    logic                  Flush;
    logic [ADDR:0]         Busy_Cnt;

    modport master (
        output Write_Reg, W_Addr, W_Data, W_Be, W_Release,
        output R_Addr,
        input  R_Data, R_Busy,
        output Sb_Set, Sb_Addr, Flush,
        input  Busy_Cnt
    );

    modport slave (
        input  Write_Reg, W_Addr, W_Data, W_Be, W_Release,
        input  R_Addr,
        output R_Data, R_Busy,
        input  Sb_Set, Sb_Addr, Flush,
        output Busy_Cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight producers, with forwarded release on
// the read side and a running count of busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR     = ADDR_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                Clk,
    input  logic                Clr,
    input  logic                Sb_Set,
    input  logic [ADDR-1:0]     Sb_Addr,
    input  logic                W_Rel,
    input  logic [ADDR-1:0]     Rel_Addr,
    input  logic                Flush,
    input  logic [NRD*ADDR-1:0] R_Addr,
    output logic [NRD-1:0]      R_Busy,
    output logic [ADDR:0]       Busy_Cnt
);

    localparam int NUMB     = 1 << ADDR;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [NUMB-1:0] busy, busy_nxt;
    logic [ADDR:0]   cnt_nxt;
    logic            set_eff;
    logic            inc;
    logic            dec;
    logic [NRD-1:0]  r_busy;

    // r0 is hard-wired, so it can never have a pending producer.
    assign set_eff = Sb_Set && !(HAS_ZERO && (Sb_Addr == '0));

    // Next busy vector and count: release first, then set, so a newer producer wins.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        busy_nxt = busy;
        cnt_nxt  = Busy_Cnt;
        inc      = set_eff && !busy[Sb_Addr];
        dec      = W_Rel && busy[Rel_Addr] && !(set_eff && (Sb_Addr == Rel_Addr));
        if (Flush) begin
            busy_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (W_Rel)   busy_nxt[Rel_Addr] = 1'b0;
            if (set_eff) busy_nxt[Sb_Addr]  = 1'b1;
            cnt_nxt = Busy_Cnt + {{ADDR{1'b0}}, inc} - {{ADDR{1'b0}}, dec};
        end
    end

    // Busy state and count update; reset clears everything and drops this cycle's set.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            busy     <= '0;
            Busy_Cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            Busy_Cnt <= cnt_nxt;
        end
    end

    // Operand busy per read port; a release this cycle is forwarded, a set is not.
    for (genvar p = 0; p < NRD; p++) begin : g_rbusy
        logic [ADDR-1:0] ra;
        assign ra        = R_Addr[p*ADDR +: ADDR];
        assign r_busy[p] = busy[ra]
                         && !(W_Rel && (Rel_Addr == ra))
                         && !(HAS_ZERO && (ra == '0));
    end

    assign R_Busy = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// ID-stage register file: NRD combinational read ports, one byte-enabled
// write port with same-cycle forwarding, and an attached scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int ADDR       = ADDR_DEF,
    parameter int SIZE       = SIZE_DEF,
    parameter int NRD        = 2,
    parameter int ZERO_REG   = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic         Clk,
    input  logic         Clr,
    regfile_sb_if.slave  bus
);

    localparam int NUMB     = 1 << ADDR;
    localparam int NBYTE    = SIZE / 8;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [SIZE-1:0]     mem [NUMB];
    logic                wr_en;
    logic [SIZE-1:0]     wr_old;
    logic [SIZE-1:0]     wr_word;
    logic [NRD*SIZE-1:0] r_data;

    // Writes to the hard-wired r0 are dropped.
    assign wr_en  = bus.Write_Reg && !(HAS_ZERO && (bus.W_Addr == '0));
    assign wr_old = mem[bus.W_Addr];

    // Merged write word: enabled bytes from W_Data, the rest from the current contents.
    for (genvar k = 0; k < NBYTE; k++) begin : g_merge
        assign wr_word[k*8 +: 8] = be_merge_byte(wr_old[k*8 +: 8], bus.W_Data[k*8 +: 8], bus.W_Be[k]);
    end

    // Register array: reset preload, then rising-edge byte-merged write.
    always_ff @(posedge Clk) begin
        // NOTE: the array is reset on purpose because software relies on the preload; state uses <= so every flop samples pre-edge values.
        if (Clr) begin
            for (int i = 0; i < NUMB; i++) begin
                mem[i] <= (INIT_INDEX != 0) ? SIZE'(i) : '0;
            end
        end else if (wr_en) begin
            mem[bus.W_Addr] <= wr_word;
        end
    end

    // Read ports: a same-address write is forwarded as the merged word.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR-1:0] ra;
        logic            rd_zero;
        logic            rd_fwd;
        assign ra      = bus.R_Addr[p*ADDR +: ADDR];
        assign rd_zero = HAS_ZERO && (ra == '0);
        assign rd_fwd  = wr_en && (bus.W_Addr == ra);
        assign r_data[p*SIZE +: SIZE] = rd_zero ? '0 : (rd_fwd ? wr_word : mem[ra]);
    end

    assign bus.R_Data = r_data;

    regfile_scoreboard #(
        .ADDR     (ADDR),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .Clk      (Clk),
        .Clr      (Clr),
        .Sb_Set   (bus.Sb_Set),
        .Sb_Addr  (bus.Sb_Addr),
        .W_Rel    (bus.Write_Reg && bus.W_Release),
        .Rel_Addr (bus.W_Addr),
        .Flush    (bus.Flush),
        .R_Addr   (bus.R_Addr),
        .R_Busy   (bus.R_Busy),
        .Busy_Cnt (bus.Busy_Cnt)
    );

endmodule
